// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit BCD up/down counter built from DIGITS chained decade stages.
//   Supports synchronous parallel load (with BCD validation), wrap or
//   saturate at the terminal count, and a combinational carry_out so that
//   instances cascade exactly like single decade digits.
//
// Parameters
//   DIGITS    number of BCD decades (1..8)
//   SATURATE  0 = wrap at terminal count, 1 = hold at terminal count
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears q and load_err
//   c_in       count enable / carry-in from a lower cascaded stage
//   up         direction: 1 = increment, 0 = decrement
//   load       synchronous parallel load strobe
//   load_val   BCD load value, digit i in bits [4i+3:4i]
//   q          current BCD count, digit 0 least significant
//   carry_out  combinational terminal-count pulse for cascading
//   load_err   registered; high for one cycle after a rejected load
module bcd_updown_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_in,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  carry_out,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      q_q, q_d;
  logic              load_err_q, load_err_d;

  // q_step is the count after one up/down step with wrap-around at every digit.
  logic [W-1:0]      q_step;
  // all9[i] / all0[i]: every digit below i is 9 / 0 (the per-digit ripple enables).
  logic [DIGITS:0]   all9, all0;
  logic [DIGITS-1:0] digit_ok;
  logic              at_tc;

  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] d;
      logic       step_en;
      logic [3:0] d_inc, d_dec;

      assign d           = q_q[4*i +: 4];
      assign all9[i+1]   = all9[i] & (d == 4'd9);
      assign all0[i+1]   = all0[i] & (d == 4'd0);
      assign digit_ok[i] = (load_val[4*i +: 4] <= 4'd9);
      assign step_en     = up ? all9[i] : all0[i];
      assign d_inc       = (d == 4'd9) ? 4'd0 : d + 4'd1;
      assign d_dec       = (d == 4'd0) ? 4'd9 : d - 4'd1;
      assign q_step[4*i +: 4] = !step_en ? d : (up ? d_inc : d_dec);
    end
  endgenerate

  assign at_tc     = up ? all9[DIGITS] : all0[DIGITS];
  assign carry_out = c_in & ~reset & ~load & at_tc;

  always_comb begin
    q_d        = q_q;
    load_err_d = 1'b0;
    if (reset) begin
      q_d = '0;
    end else if (load) begin
      if (&digit_ok) q_d = load_val;
      else           load_err_d = 1'b1;
    end else if (c_in) begin
      // In saturate mode the terminal value is held; carry_out still flags it.
      if (!(SATURATE && at_tc)) q_d = q_step;
    end
  end

  always_ff @(posedge clk) begin
    q_q        <= q_d;
    load_err_q <= load_err_d;
  end

  assign q        = q_q;
  assign load_err = load_err_q;

endmodule
